// File: rtl/sr_flop_bank.sv
`default_nettype none
// ============================================================================
// Module   : sr_flop_bank
// Purpose  : Bank of WIDTH clocked SR storage bits with a selectable conflict
//            resolution mode, clock enable, synchronous clear, per-bit change
//            pulses and a saturating conflict-event counter.
// Options  : define SR_FLOP_SYNC_EN to pass s and r through a 2-flop
//            synchroniser before the next-state logic (input-to-q latency
//            becomes 3 edges; en and clr stay unsynchronised).
// Revision : 1.0 - initial release
// ============================================================================
module sr_flop_bank #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_flop_bank: MODE must be 0..3");
  end

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sr_flop_bank: WIDTH must be 1..32");
  end

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("sr_flop_bank: CNT_W must be at least 1");
  end

  // Set/reset requests as seen by the next-state logic
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;

`ifdef SR_FLOP_SYNC_EN
  logic [WIDTH-1:0] s_meta;
  logic [WIDTH-1:0] s_sync;
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage synchroniser; keeps shifting regardless of en so that requests
  // arriving while the bank is disabled are not frozen mid-pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= '0;
      s_sync <= '0;
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      s_meta <= s;
      s_sync <= s_meta;
      r_meta <= r;
      r_sync <= r_meta;
    end
  end

  assign s_eff = s_sync;
  assign r_eff = r_sync;
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  // --------------------------------------------------------------------------
  // Conflict resolution value for bits with s=r=1
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] conf_val;

  if (MODE == 0) begin : g_mode_reset_dom
    assign conf_val = '0;
  end else if (MODE == 1) begin : g_mode_set_dom
    assign conf_val = '1;
  end else if (MODE == 2) begin : g_mode_hold
    assign conf_val = q;
  end else begin : g_mode_toggle
    assign conf_val = ~q;
  end

  // --------------------------------------------------------------------------
  // Next-state and conflict detection
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] hold_bits;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] conf_bits;
  logic [WIDTH-1:0] q_next;
  logic             any_conflict;
  logic             cnt_sat;

  assign hold_bits    = ~s_eff & ~r_eff;
  assign set_bits     =  s_eff & ~r_eff;
  assign conf_bits    =  s_eff &  r_eff;
  // Bits with r only fall out as 0 since they match none of the terms.
  assign q_next       = (hold_bits & q) | set_bits | (conf_bits & conf_val);
  assign any_conflict = |conf_bits;
  assign cnt_sat      = &conflict_cnt;

  // --------------------------------------------------------------------------
  // State register: clr beats en, en gates all updates of q and the counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q            <= '0;
      changed      <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (clr) begin
      q            <= '0;
      changed      <= q;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (en) begin
      q        <= q_next;
      changed  <= q_next ^ q;
      conflict <= any_conflict;
      if (any_conflict && !cnt_sat) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end else begin
      changed  <= '0;
      conflict <= 1'b0;
    end
  end

  // Complement is purely combinational from q, so it is consistent in reset too
  assign qbar = ~q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flop_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_flop_bank
// Purpose  : Directed self-checking bench for sr_flop_bank. One instance per
//            conflict MODE plus a narrow-counter instance, all sharing stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_flop_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] s;
  logic [7:0] r;

  logic [7:0] q0, qb0, ch0;  logic cf0;  logic [7:0] cnt0;
  logic [7:0] q1, qb1, ch1;  logic cf1;  logic [7:0] cnt1;
  logic [7:0] q2, qb2, ch2;  logic cf2;  logic [7:0] cnt2;
  logic [7:0] q3, qb3, ch3;  logic cf3;  logic [7:0] cnt3;
  logic [7:0] qc, qbc, chc;  logic cfc;  logic [1:0] cntc;

  int errors = 0;
  int checks = 0;

  sr_flop_bank #(.WIDTH(8), .MODE(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q0), .qbar(qb0), .changed(ch0), .conflict(cf0), .conflict_cnt(cnt0));

  sr_flop_bank #(.WIDTH(8), .MODE(1), .CNT_W(8)) dut_m1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q1), .qbar(qb1), .changed(ch1), .conflict(cf1), .conflict_cnt(cnt1));

  sr_flop_bank #(.WIDTH(8), .MODE(2), .CNT_W(8)) dut_m2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q2), .qbar(qb2), .changed(ch2), .conflict(cf2), .conflict_cnt(cnt2));

  sr_flop_bank #(.WIDTH(8), .MODE(3), .CNT_W(8)) dut_m3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q3), .qbar(qb3), .changed(ch3), .conflict(cf3), .conflict_cnt(cnt3));

  sr_flop_bank #(.WIDTH(8), .MODE(0), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(qc), .qbar(qbc), .changed(chc), .conflict(cfc), .conflict_cnt(cntc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; s = '0; r = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk8("reset_q", q0, 8'h00);
    chk8("reset_qbar", qb0, 8'hFF);
    chk8("reset_changed", ch0, 8'h00);
    chk8("reset_conflict", {7'd0, cf0}, 8'h00);
    chk8("reset_cnt", cnt0, 8'h00);
    #3 rst_n = 1'b1;
  endtask

`ifndef SR_FLOP_SYNC_EN
  task automatic test_set_hold();
    en = 1'b1; s = 8'h0F; r = 8'h00;
    tick();
    chk8("set_q", q0, 8'h0F);
    chk8("set_qbar", qb0, 8'hF0);
    chk8("set_changed", ch0, 8'h0F);
    chk8("set_conflict", {7'd0, cf0}, 8'h00);
    s = 8'h00;
    tick();
    chk8("hold_q", q0, 8'h0F);
    chk8("hold_changed", ch0, 8'h00);
  endtask

  task automatic test_conflict_modes();
    s = 8'h03; r = 8'h03;
    tick();
    chk8("m0_q", q0, 8'h0C);
    chk8("m0_changed", ch0, 8'h03);
    chk8("m0_conflict", {7'd0, cf0}, 8'h01);
    chk8("m0_cnt", cnt0, 8'h01);
    chk8("m1_q", q1, 8'h0F);
    chk8("m1_changed", ch1, 8'h00);
    chk8("m1_cnt", cnt1, 8'h01);
    chk8("m2_q", q2, 8'h0F);
    chk8("m3_q", q3, 8'h0C);
    chk8("m3_changed", ch3, 8'h03);
    tick();
    chk8("m3_q_2nd", q3, 8'h0F);
    chk8("m0_q_2nd", q0, 8'h0C);
    chk8("m0_changed_2nd", ch0, 8'h00);
    chk8("m0_cnt_2nd", cnt0, 8'h02);
    chk8("m2_q_2nd", q2, 8'h0F);
    chk8("m1_q_2nd", q1, 8'h0F);
  endtask

  task automatic test_enable_clear();
    en = 1'b0; s = 8'hFF; r = 8'h00;
    tick();
    chk8("en0_q", q0, 8'h0C);
    chk8("en0_changed", ch0, 8'h00);
    chk8("en0_conflict", {7'd0, cf0}, 8'h00);
    chk8("en0_cnt", cnt0, 8'h02);
    // bring MODE 0 instance back to 0F
    en = 1'b1; s = 8'h03; r = 8'h00;
    tick();
    chk8("reset_to_0f", q0, 8'h0F);
    en = 1'b0; clr = 1'b1; s = 8'h00;
    tick();
    chk8("clr_q", q0, 8'h00);
    chk8("clr_qbar", qb0, 8'hFF);
    chk8("clr_changed", ch0, 8'h0F);
    chk8("clr_cnt", cnt0, 8'h00);
    chk8("clr_conflict", {7'd0, cf0}, 8'h00);
    chk8("clr_m3_changed", ch3, 8'h0F);
    clr = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c2 [6];
    exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    en = 1'b1; s = 8'h81; r = 8'h81;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk8($sformatf("sat_cnt2_%0d", i), {6'd0, cntc}, {6'd0, exp_c2[i]});
      chk8($sformatf("sat_conflict_%0d", i), {7'd0, cfc}, 8'h01);
      chk8($sformatf("sat_cnt8_%0d", i), cnt0, 8'(i + 1));
    end
    s = 8'h00; r = 8'h00;
    tick();
    chk8("sat_conflict_end", {7'd0, cfc}, 8'h00);
    chk8("sat_cnt2_hold", {6'd0, cntc}, 8'h03);
  endtask

  task automatic test_async_reset();
    s = 8'hAA; r = 8'h00;
    tick();
    chk8("pre_async_q", q0, 8'hAA);
    s = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    chk8("async_q", q0, 8'h00);
    chk8("async_qbar", qb0, 8'hFF);
    chk8("async_cnt", cnt0, 8'h00);
    chk8("async_m1_q", q1, 8'h00);
    tick();
    #2 rst_n = 1'b1;
    s = 8'h01;
    tick();
    chk8("post_reset_q", q0, 8'h01);
    chk8("post_reset_changed", ch0, 8'h01);
  endtask

  task automatic test_back_to_back();
    s = 8'h00; r = 8'h01;
    tick();
    chk8("b2b_clear_q", q0, 8'h00);
    chk8("b2b_clear_changed", ch0, 8'h01);
    s = 8'hF0; r = 8'h00;
    tick();
    chk8("b2b_set_q", q0, 8'hF0);
    s = 8'hF0; r = 8'h00;
    tick();
    chk8("b2b_reset_set_changed", ch0, 8'h00);
    s = 8'h00; r = 8'h30;
    tick();
    chk8("b2b_partial_q", q0, 8'hC0);
    chk8("b2b_partial_changed", ch0, 8'h30);
    chk8("b2b_partial_qbar", qb0, 8'h3F);
  endtask
`else
  task automatic test_sync_latency();
    en = 1'b1; s = 8'h01; r = 8'h00;
    tick();
    chk8("sync_q_edge1", q0, 8'h00);
    s = 8'h00;
    tick();
    chk8("sync_q_edge2", q0, 8'h00);
    tick();
    chk8("sync_q_edge3", q0, 8'h01);
    chk8("sync_changed_edge3", ch0, 8'h01);
    tick();
    chk8("sync_q_edge4", q0, 8'h01);
    chk8("sync_changed_edge4", ch0, 8'h00);
    // en and clr act immediately, unsynchronised
    clr = 1'b1;
    tick();
    chk8("sync_clr_q", q0, 8'h00);
    clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef SR_FLOP_SYNC_EN
    test_set_hold();
    test_conflict_modes();
    test_enable_clear();
    test_saturate();
    test_async_reset();
    test_back_to_back();
`else
    test_sync_latency();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
